// File: rtl/m_stage_dm.sv
// Memory-access stage: byte-lane data memory, load extension,
// W->M store-data forwarding and the M/W pipeline register.
module m_stage_dm #(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result_M_i,
  input  logic [31:0] RD2_M_i,
  input  logic [4:0]  A2_M_i,
  input  logic [31:0] PCn_M_i,
  input  logic [31:0] OP_M_i,
  input  logic        regWrite_M_i,
  input  logic [4:0]  A3_M_i,
  output logic [31:0] result_W_i,
  output logic [31:0] DMRD_W_i,
  output logic [31:0] PCn_W_i,
  output logic [31:0] OP_W_i,
  output logic [4:0]  A3_W_i,
  output logic        regWrite_W_i,
  output logic [31:0] W_result,
  output logic        W_regWrite,
  output logic [4:0]  W_A3
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] mem [DM_WORDS];

  logic [5:0]       opc;
  logic [DM_AW-1:0] widx;
  logic [1:0]       lane;
  logic [31:0]      rword;
  logic [15:0]      rhalf;
  logic [7:0]       rbyte;
  logic [31:0]      sd;
  logic [31:0]      ld;
  logic             is_lw, is_lh, is_lhu, is_lb, is_lbu;
  logic             is_sw, is_sh, is_sb;
  logic             w_is_load;
  logic [5:0]       w_opc;

  assign opc    = OP_M_i[31:26];
  assign widx   = result_M_i[DM_AW+1:2];
  assign lane   = result_M_i[1:0];
  assign is_lw  = (opc == OP_LW);
  assign is_lh  = (opc == OP_LH);
  assign is_lhu = (opc == OP_LHU);
  assign is_lb  = (opc == OP_LB);
  assign is_lbu = (opc == OP_LBU);
  assign is_sw  = (opc == OP_SW);
  assign is_sh  = (opc == OP_SH);
  assign is_sb  = (opc == OP_SB);

  assign rword = mem[widx];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];
  assign rbyte = rword[{lane, 3'b000} +: 8];

  // Forward the value being written back this cycle
  assign sd = (W_regWrite && (W_A3 == A2_M_i) && (A2_M_i != 5'd0))
            ? W_result : RD2_M_i;

  always_comb begin
    ld = '0;
    unique case (1'b1)
      is_lw:   ld = rword;
      is_lh:   ld = {{16{rhalf[15]}}, rhalf};
      is_lhu:  ld = {16'd0, rhalf};
      is_lb:   ld = {{24{rbyte[7]}}, rbyte};
      is_lbu:  ld = {24'd0, rbyte};
      default: ld = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else begin
      if (is_sw) mem[widx] <= sd;
      if (is_sh) begin
        if (lane[1]) mem[widx][31:16] <= sd[15:0];
        else         mem[widx][15:0]  <= sd[15:0];
      end
      if (is_sb) mem[widx][{lane, 3'b000} +: 8] <= sd[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_W_i   <= '0;
      DMRD_W_i     <= '0;
      PCn_W_i      <= '0;
      OP_W_i       <= '0;
      A3_W_i       <= '0;
      regWrite_W_i <= 1'b0;
    end else begin
      result_W_i   <= result_M_i;
      DMRD_W_i     <= ld;
      PCn_W_i      <= PCn_M_i;
      OP_W_i       <= OP_M_i;
      A3_W_i       <= A3_M_i;
      regWrite_W_i <= regWrite_M_i;
    end
  end

  assign w_opc     = OP_W_i[31:26];
  assign w_is_load = (w_opc == OP_LW)  || (w_opc == OP_LH) ||
                     (w_opc == OP_LHU) || (w_opc == OP_LB) ||
                     (w_opc == OP_LBU);

  assign W_result   = w_is_load ? DMRD_W_i : result_W_i;
  assign W_regWrite = regWrite_W_i;
  assign W_A3       = A3_W_i;

endmodule
